// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Sequencer for the binary-to-Gray datapath. Holds a WIDTH-bit binary count,
//   steps it up or down on each accepted beat, and presents the registered
//   Gray-coded value (g = b ^ (b >> 1)) to a downstream consumer.
//   Supports load, start/stop, and either wrap-around or one-shot operation.
//
//   Optional feature macro: GRAY_SEQ_CHECK_EN
//     When defined, adds the sticky err output plus a register of the last
//     transferred Gray value; err sets if two consecutive transferred Gray
//     values within one run differ by other than exactly one bit.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin sequencing (IDLE only)
//   stop       in   end sequencing (RUN only, priority over start)
//   load       in   load load_val into the count (IDLE only)
//   load_val   in   [WIDTH-1:0] binary load value
//   dir_up     in   1 = increment, 0 = decrement (sampled per transfer)
//   mode_wrap  in   1 = wrap at terminal, 0 = one-shot (sampled per transfer)
//   out_ready  in   consumer ready
//   out_valid  out  gray_out/bin_out valid
//   gray_out   out  [WIDTH-1:0] registered Gray value of bin_out
//   bin_out    out  [WIDTH-1:0] registered binary count
//   busy       out  high in RUN
//   done       out  one-cycle pulse when a one-shot run completes
//   err        out  sticky Gray-adjacency error (GRAY_SEQ_CHECK_EN only)
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready.
// While out_valid is high and no transfer occurs, gray_out/bin_out/out_valid
// hold stable. out_valid never depends combinationally on out_ready.

module gray_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_up,
  input  logic             mode_wrap,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
`ifdef GRAY_SEQ_CHECK_EN
  output logic             done,
  output logic             err
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t           state;
  logic             xfer;
  logic             at_terminal;
  logic [WIDTH-1:0] bin_step;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The wrap cases (MAX+1 -> 0, 0-1 -> MAX) fall out of modular arithmetic.
  always_comb begin
    xfer        = out_valid & out_ready;
    at_terminal = dir_up ? (bin_out == MAX_VAL) : (bin_out == '0);
    bin_step    = dir_up ? (bin_out + 1'b1) : (bin_out - 1'b1);
  end

  // gray_out is always loaded from the same value as bin_out on the same edge,
  // so the two outputs never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bin_out   <= '0;
      gray_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load) begin
            bin_out  <= load_val;
            gray_out <= to_gray(load_val);
          end
          if (start) begin
            state     <= S_RUN;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          // A beat accepted in the same cycle as stop still completes.
          if (xfer) begin
            if (at_terminal && !mode_wrap) begin
              // One-shot end: count holds the terminal value.
              state     <= S_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              bin_out  <= bin_step;
              gray_out <= to_gray(bin_step);
            end
          end
          if (stop) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] last_gray;
  logic             have_last;

  // have_last is cleared on every start so the first beat of a run is
  // never compared against the tail of the previous run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gray <= '0;
      have_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        have_last <= 1'b0;
      end else if (state == S_RUN && xfer) begin
        if (have_last && ($countones(gray_out ^ last_gray) != 1)) begin
          err <= 1'b1;
        end
        last_gray <= gray_out;
        have_last <= 1'b1;
      end
    end
  end
`endif

endmodule
